// File: rtl/proc_ctrl_pkg.sv
// rtl/proc_ctrl_pkg.sv - shared types, constants and helpers for the control-step decoder
// Contents: state_t (IDLE/RUN), clog2() helper, default T-state instance sizes.
package proc_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default sizing for the processor T-state generator instance
    localparam int TSTATE_SEL_W   = 3;
    localparam int TSTATE_NUM_OUT = 8;

    // Ceiling log2, usable at elaboration time; clog2(1) == 0
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_step_decoder_if.sv
// rtl/onehot_step_decoder_if.sv - control/status bundle of the one-hot step decoder
// Ports: master drives en/clear/load/load_sel/step/cyclic/last_step and
// observes onehot/sel_out/busy/wrap/err; slave is the decoder side.
interface onehot_step_decoder_if #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8
);
    logic               en;
    logic               clear;
    logic               load;
    logic [SEL_W-1:0]   load_sel;
    logic               step;
    logic               cyclic;
    logic [SEL_W-1:0]   last_step;
    logic [NUM_OUT-1:0] onehot;
    logic [SEL_W-1:0]   sel_out;
    logic               busy;
    logic               wrap;
    logic               err;

    modport master (
        output en, clear, load, load_sel, step, cyclic, last_step,
        input  onehot, sel_out, busy, wrap, err
    );

    modport slave (
        input  en, clear, load, load_sel, step, cyclic, last_step,
        output onehot, sel_out, busy, wrap, err
    );
endinterface

// File: rtl/onehot_step_decoder_dec.sv
// rtl/onehot_step_decoder_dec.sv - combinational SEL_W-to-NUM_OUT one-hot decoder with enable
// Ports: sel (index), en (0 forces all lines low), lines (one-hot result).
module onehot_dec #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8
) (
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    output logic [NUM_OUT-1:0] lines
);
    always_comb begin
        lines = '0;
        if (en) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                lines[i] = (sel == SEL_W'(i));
            end
        end
    end
endmodule

// File: rtl/onehot_step_decoder.sv
// rtl/onehot_step_decoder.sv - registered one-hot control-step generator with IDLE/RUN gating
// Ports: clk, rst_n (async active-low), bus (slave side of onehot_step_decoder_if):
// en/clear/load/load_sel/step/cyclic/last_step in; onehot/sel_out/busy/wrap/err out.
module onehot_step_decoder
    import proc_ctrl_pkg::*;
#(
    parameter int SEL_W   = TSTATE_SEL_W,
    parameter int NUM_OUT = TSTATE_NUM_OUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onehot_step_decoder_if.slave  bus
);
    generate
        if (NUM_OUT < 2 || clog2(NUM_OUT) > SEL_W) begin : g_bad_num_out
            $error("onehot_step_decoder: NUM_OUT must lie in 2..2**SEL_W");
        end
    endgenerate

    // One extra bit so NUM_OUT == 2**SEL_W still compares correctly
    localparam logic [SEL_W:0]   NUM_OUT_W = (SEL_W+1)'(NUM_OUT);
    localparam logic [SEL_W-1:0] MAX_SEL   = SEL_W'(NUM_OUT - 1);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [SEL_W-1:0]     eff_last;
    logic                 at_end;
    logic                 wrap_q, wrap_d;
    logic                 err_q, err_d;
    logic [NUM_OUT-1:0]   onehot_q, onehot_d;

    always_comb begin
        eff_last = ({1'b0, bus.last_step} >= NUM_OUT_W) ? MAX_SEL : bus.last_step;
        // A select beyond eff_last runs up to the top line and wraps there,
        // so the index can never leave the decoder's range.
        at_end   = (sel_q == eff_last) || (sel_q == MAX_SEL);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            sel_d   = '0;
        end else if (bus.en) begin
            if (bus.load) begin
                if ({1'b0, bus.load_sel} < NUM_OUT_W) begin
                    state_d = RUN;
                    sel_d   = bus.load_sel;
                end else begin
                    err_d = 1'b1;
                end
            end else if (bus.step && state_q == RUN) begin
                if (at_end) begin
                    wrap_d  = 1'b1;
                    sel_d   = '0;
                    state_d = bus.cyclic ? RUN : IDLE;
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                end
            end
        end
    end

    // Decode the next value so onehot lands on the same edge as sel_out
    onehot_dec #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_dec (
        .sel   (sel_d),
        .en    (state_d == RUN),
        .lines (onehot_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            onehot_q <= '0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            onehot_q <= onehot_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    assign bus.onehot  = onehot_q;
    assign bus.sel_out = sel_q;
    assign bus.busy    = (state_q == RUN);
    assign bus.wrap    = wrap_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_onehot_step_decoder.sv
// tb/tb_onehot_step_decoder.sv - self-checking bench for onehot_step_decoder (NUM_OUT 8 and 6)
module tb_onehot_step_decoder;
    logic clk;
    logic rst_n;

    onehot_step_decoder_if #(.SEL_W(3), .NUM_OUT(8)) if8 ();
    onehot_step_decoder_if #(.SEL_W(3), .NUM_OUT(6)) if6 ();

    onehot_step_decoder #(.SEL_W(3), .NUM_OUT(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    onehot_step_decoder #(.SEL_W(3), .NUM_OUT(6)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 -> NUM_OUT=8 instance, index 1 -> NUM_OUT=6
    int nout   [2] = '{8, 6};
    int m_run  [2];
    int m_sel  [2];
    int m_wrap [2];
    int m_err  [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_onehot(input int k);
        return (m_run[k] != 0) ? (32'd1 << m_sel[k]) : 32'd0;
    endfunction

    task automatic check_all();
        check_eq("n8.onehot",  32'(if8.onehot),  exp_onehot(0));
        check_eq("n8.sel_out", 32'(if8.sel_out), 32'(m_sel[0]));
        check_eq("n8.busy",    32'(if8.busy),    32'(m_run[0]));
        check_eq("n8.wrap",    32'(if8.wrap),    32'(m_wrap[0]));
        check_eq("n8.err",     32'(if8.err),     32'(m_err[0]));
        check_eq("n6.onehot",  32'(if6.onehot),  exp_onehot(1));
        check_eq("n6.sel_out", 32'(if6.sel_out), 32'(m_sel[1]));
        check_eq("n6.busy",    32'(if6.busy),    32'(m_run[1]));
        check_eq("n6.wrap",    32'(if6.wrap),    32'(m_wrap[1]));
        check_eq("n6.err",     32'(if6.err),     32'(m_err[1]));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_sel[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
        end
    endtask

    // Apply one clock of stimulus to both instances, advance the model, check
    task automatic cyc(input bit c, input bit e, input bit l, input int ls,
                       input bit s, input bit cy, input int last);
        if8.clear = c; if8.en = e; if8.load = l; if8.load_sel = 3'(ls);
        if8.step = s; if8.cyclic = cy; if8.last_step = 3'(last);
        if6.clear = c; if6.en = e; if6.load = l; if6.load_sel = 3'(ls);
        if6.step = s; if6.cyclic = cy; if6.last_step = 3'(last);
        for (int k = 0; k < 2; k++) begin
            int eff;
            eff = (last < nout[k]) ? last : nout[k] - 1;
            m_wrap[k] = 0;
            m_err[k]  = 0;
            if (c) begin
                m_run[k] = 0;
                m_sel[k] = 0;
            end else if (e && l) begin
                if (ls < nout[k]) begin
                    m_run[k] = 1;
                    m_sel[k] = ls;
                end else begin
                    m_err[k] = 1;
                end
            end else if (e && s && m_run[k] != 0) begin
                if (m_sel[k] == eff || m_sel[k] == nout[k] - 1) begin
                    m_wrap[k] = 1;
                    m_sel[k]  = 0;
                    m_run[k]  = cy ? 1 : 0;
                end else begin
                    m_sel[k] = m_sel[k] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);

        // Load 5 -> 0x20 on the next edge
        cyc(0, 1, 1, 5, 0, 0, 7);
        check_eq("load5.onehot", 32'(if8.onehot), 32'h20);

        // Cyclic full run 0..7 and back to 0 (NUM_OUT=6 wraps at 5)
        cyc(0, 1, 1, 0, 0, 1, 7);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 1, 1, 7);
        check_eq("cyc.wrapped", 32'(if8.onehot), 32'h01);

        // One-shot run with last_step 3, then an ignored extra step
        cyc(0, 1, 1, 0, 0, 0, 3);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1, 0, 3);
        check_eq("oneshot.idle", 32'(if8.busy), 32'd0);
        cyc(0, 1, 0, 0, 1, 0, 3);

        // Rejected load on NUM_OUT=6 (6 and 7), accepted on 8
        cyc(0, 1, 1, 6, 0, 1, 7);
        cyc(0, 1, 1, 7, 0, 1, 7);

        // Select beyond eff_last, then change of last_step mid-run
        cyc(0, 1, 1, 4, 0, 1, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1, 1, 1);

        // Priority: clear beats load/step even with en low; load beats step
        cyc(1, 0, 1, 3, 1, 1, 7);
        check_eq("clear.onehot", 32'(if8.onehot), 32'h00);
        cyc(0, 1, 1, 2, 1, 1, 7);
        check_eq("loadwins.sel", 32'(if8.sel_out), 32'd2);
        cyc(0, 0, 0, 0, 1, 1, 7);

        // Half-cycle reset pulse mid-run
        cyc(0, 1, 0, 0, 1, 1, 7);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        #3;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 15) == 0),
                ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 5) == 0),
                int'($urandom_range(0, 7)),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/onehot_step_decoder.md
Name: onehot_step_decoder

Overview:
- Parametrised, registered successor to the fixed 3-to-8 decoder.
- Holds a select value in a step register, advanced by a step strobe or loaded directly.
- Drives a glitch-free one-hot bus of NUM_OUT lines, gated by an IDLE/RUN state.
- Used as the processor's control-step (T-state) generator and register-file write-enable decoder; supports cyclic and one-shot sequencing with a programmable last step.

Parameters:
- SEL_W, 3, width of select/step value.
- NUM_OUT, 8, number of one-hot outputs. Legal range 2..2**SEL_W; an illegal value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  qualifies load and step; clear is not gated by en
- clear  in  1  synchronous return to IDLE
- load  in  1  load load_sel and enter RUN
- load_sel  in  SEL_W  value to load
- step  in  1  advance one step, RUN only
- cyclic  in  1  1 = wrap to 0 and stay in RUN; 0 = one-shot, return to IDLE after the last step
- last_step  in  SEL_W  final step index; values >= NUM_OUT are treated as NUM_OUT-1
- onehot  out  NUM_OUT  registered one-hot decode; all-zero in IDLE
- sel_out  out  SEL_W  current step register
- busy  out  1  1 in RUN
- wrap  out  1  one-cycle pulse on the step that leaves last_step
- err  out  1  one-cycle pulse on a rejected load

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, sel_out=0, onehot=0, busy=0, wrap=0, err=0.
  - Reset mid-RUN aborts immediately; no wrap pulse is generated.
- States: IDLE, RUN.
- Per-edge priority: clear > load > step.
  - Lower-priority requests in the same cycle are dropped, not queued.
- clear=1: next state IDLE, sel_out=0, onehot=0, wrap=0, err=0. Applies regardless of en.
- en=0 (and clear=0): state, sel_out and onehot hold; wrap=0, err=0.
- load=1, en=1:
  - If load_sel < NUM_OUT: state RUN, sel_out=load_sel. Legal in IDLE or RUN.
  - If load_sel >= NUM_OUT: err=1 for one cycle; state and sel_out unchanged.
- step=1, en=1, load=0, state=RUN:
  - sel_out != eff_last: sel_out+1.
  - sel_out == eff_last: wrap=1 for one cycle and sel_out=0; state remains RUN if cyclic=1, becomes IDLE if cyclic=0.
  - eff_last = min(last_step, NUM_OUT-1).
- step in IDLE: ignored, no pulses.
- sel_out > eff_last can occur, via a load or a change of last_step. Stepping then increments normally up to NUM_OUT-1, then wraps as if at eff_last. It never produces an out-of-range index.
- cyclic and last_step are sampled on each step edge; changing them mid-run takes effect at the next step.
- onehot is registered on the same edge as sel_out: onehot[i] = (next_state==RUN && next_sel==i).
  - Latency from load/step to onehot is 1 clock.
  - onehot has exactly one bit set in RUN and is zero in IDLE. No combinational path from inputs to outputs.
- busy = (state==RUN), registered.
- wrap and err are default-0 single-cycle pulses.
- Widths: sel arithmetic is SEL_W bits, and the range check uses NUM_OUT. A SEL_W-bit overflow can never be reached.

Decomposition:
- Shared package (proc_ctrl_pkg):
  - state enum {IDLE, RUN}
  - clog2 helper function
  - default SEL_W/NUM_OUT constants for the T-state instance
- One natural sub-module: onehot_dec, a purely combinational SEL_W-to-NUM_OUT decoder with an enable input. It is instantiated on next_sel, and its output is registered in the parent.

Test Plan:
- Reset, then release with all inputs low -> onehot=0x00, sel_out=0, busy=0 at every cycle.
- load=1, load_sel=5, en=1 (SEL_W=3, NUM_OUT=8) -> next cycle onehot=0x20, sel_out=5, busy=1.
- Cyclic run: cyclic=1, last_step=7, load 0, then 8 steps -> onehot 0x01,0x02,...,0x80,0x01; wrap pulses only on the step 7->0; busy stays 1.
- One-shot run: cyclic=0, last_step=3, load 0, then 4 steps -> onehot 0x01..0x08, then 0x00; wrap=1 and busy falls on the same edge; a further step is ignored.
- NUM_OUT=6 instance: load_sel=6 -> err=1 for one cycle, state unchanged. Same instance with last_step=7 -> wrap at 5->0.
- Priority and reset:
  - clear+load+step in the same cycle with en=0 -> IDLE, onehot=0.
  - load+step together -> load value wins.
  - rst_n low for half a cycle mid-RUN -> outputs zero immediately, no wrap.
